// File: rtl/gbuff_stream_reader_pkg.sv
// Shared widths and FSM encoding for the global-buffer stream reader.
// Word and index widths follow GBUF_WORD_W / GBUF_IDX_W when the build defines them.
`ifndef GBUF_WORD_W
`define GBUF_WORD_W 32
`endif
`ifndef GBUF_IDX_W
`define GBUF_IDX_W 8
`endif

package gbuff_stream_reader_pkg;

  localparam int unsigned DATA_W = `GBUF_WORD_W;
  localparam int unsigned IDX_W  = `GBUF_IDX_W;
  // One extra bit so a full-bank burst (2^IDX_W words) is representable.
  localparam int unsigned LEN_W  = IDX_W + 1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } rd_state_e;

  function automatic logic [IDX_W-1:0] next_index(input logic [IDX_W-1:0] idx,
                                                  input logic [IDX_W-1:0] step);
    return idx + step;
  endfunction

endpackage

// File: rtl/gbuff_stream_reader_if.sv
// Command, buffer-port and output-stream signals of the reader.
// The stride input exists only when GBUF_RD_STRIDE_EN is defined.
interface gbuff_stream_reader_if import gbuff_stream_reader_pkg::*; ();

  logic              start;
  logic [IDX_W-1:0]  base_idx;
  logic [LEN_W-1:0]  length;
`ifdef GBUF_RD_STRIDE_EN
  logic [IDX_W-1:0]  stride;
`endif
  logic              busy;
  logic              done;
  logic              gb_wr_en;
  logic [IDX_W-1:0]  gb_index;
  logic [DATA_W-1:0] gb_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport slave (
    input  start, base_idx, length,
`ifdef GBUF_RD_STRIDE_EN
    input  stride,
`endif
    input  gb_data, out_ready,
    output busy, done, gb_wr_en, gb_index, out_valid, out_data, out_last
  );

  modport master (
    output start, base_idx, length,
`ifdef GBUF_RD_STRIDE_EN
    output stride,
`endif
    output gb_data, out_ready,
    input  busy, done, gb_wr_en, gb_index, out_valid, out_data, out_last
  );

endinterface

// File: rtl/gbuff_skid_fifo.sv
// Two-entry FIFO with a registered head; push and pop in the same cycle are
// accepted whether the FIFO is empty or full.
module gbuff_skid_fifo import gbuff_stream_reader_pkg::*; #(
  parameter int unsigned Width = DATA_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] head,
  output logic [1:0]       count
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_push, do_pop;

  always_comb begin
    do_pop  = pop && (count_q != 2'd0);
    do_push = push && ((count_q != 2'd2) || do_pop);
    head    = mem_q[rd_ptr_q];
    count   = count_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/gbuff_stream_reader.sv
// Burst reader for one global-buffer bank: issues indices, absorbs the 1-cycle read
// latency and streams words out through a skid FIFO. Stride option: GBUF_RD_STRIDE_EN.
module gbuff_stream_reader import gbuff_stream_reader_pkg::*; (
  input logic                  clk,
  input logic                  rst,
  gbuff_stream_reader_if.slave bus
);

  rd_state_e         state_q, state_d;
  logic [IDX_W-1:0]  cur_idx_q, idx_hold_q;
  logic [LEN_W-1:0]  len_q, issued_q;
  logic              inflight_q, inflight_last_q;
  logic [IDX_W-1:0]  step;
  logic              issue, last_issue, pop, out_valid;
  logic [2:0]        occupancy;
  logic [1:0]        fifo_count;
  logic [DATA_W:0]   fifo_head;

`ifdef GBUF_RD_STRIDE_EN
  logic [IDX_W-1:0]  step_q;
  assign step = step_q;
`else
  assign step = IDX_W'(1);
`endif

  gbuff_skid_fifo #(
    .Width(DATA_W + 1)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight_q),
    .push_data({inflight_last_q, bus.gb_data}),
    .pop      (pop),
    .head     (fifo_head),
    .count    (fifo_count)
  );

  always_comb begin
    out_valid  = (fifo_count != 2'd0);
    pop        = out_valid && bus.out_ready;
    occupancy  = {1'b0, fifo_count} + {2'b0, inflight_q};
    // Only issue when the word is guaranteed a FIFO slot on arrival.
    issue      = (state_q == StFetch) && ((occupancy - {2'b0, pop}) < 3'd2);
    last_issue = issue && (issued_q == (len_q - 1'b1));

    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) state_d = (bus.length == '0) ? StDone : StFetch;
      end
      StFetch: begin
        if (last_issue) state_d = StDrain;
      end
      StDrain: begin
        if (pop && fifo_head[DATA_W]) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    bus.busy      = (state_q == StFetch) || (state_q == StDrain);
    bus.done      = (state_q == StDone);
    bus.gb_wr_en  = 1'b0;
    bus.gb_index  = issue ? cur_idx_q : idx_hold_q;
    bus.out_valid = out_valid;
    bus.out_data  = out_valid ? fifo_head[DATA_W-1:0] : '0;
    bus.out_last  = out_valid && fifo_head[DATA_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StIdle;
      cur_idx_q       <= '0;
      idx_hold_q      <= '0;
      len_q           <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
`ifdef GBUF_RD_STRIDE_EN
      step_q          <= '0;
`endif
    end else begin
      state_q         <= state_d;
      inflight_q      <= issue;
      inflight_last_q <= last_issue;
      if ((state_q == StIdle) && bus.start) begin
        cur_idx_q <= bus.base_idx;
        len_q     <= bus.length;
        issued_q  <= '0;
`ifdef GBUF_RD_STRIDE_EN
        step_q    <= bus.stride;
`endif
      end else if (issue) begin
        cur_idx_q  <= next_index(cur_idx_q, step);
        idx_hold_q <= cur_idx_q;
        issued_q   <= issued_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gbuff_stream_reader.sv
// Randomised bench for gbuff_stream_reader against a queue-based reference of the
// expected word stream; also covers the stride option when GBUF_RD_STRIDE_EN is set.
module tb_gbuff_stream_reader;
  import gbuff_stream_reader_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gbuff_stream_reader_if bus ();

  gbuff_stream_reader dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Buffer bank: registered read, mem[i] = i + 0x100.
  logic [DATA_W-1:0] mem [256];
  always @(posedge clk) bus.gb_data <= mem[bus.gb_index];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_index(input int base, input int n, input int step);
    return (base + n * step) % 256;
  endfunction

  // mode 0: ready always high, 1: ready pattern 1,0,0 repeating, 2: random ready.
  task automatic run_burst(input int base, input int len, input int step, input int mode,
                           input bit chk_lat);
    logic [DATA_W-1:0] exp_data [$];
    bit                exp_last [$];
    int                cyc, last_hs;
    bit                finished, prev_stall, exp_done, exp_busy;
    logic [DATA_W-1:0] prev_data;
    logic [IDX_W-1:0]  idx_before;

    for (int n = 0; n < len; n++) begin
      exp_data.push_back(DATA_W'(ref_index(base, n, step) + 'h100));
      exp_last.push_back(n == len - 1);
    end
    idx_before = bus.gb_index;

    @(negedge clk);
    bus.start    = 1'b1;
    bus.base_idx = IDX_W'(base);
    bus.length   = LEN_W'(len);
`ifdef GBUF_RD_STRIDE_EN
    bus.stride   = IDX_W'(step);
`endif
    @(negedge clk);
    bus.start = 1'b0;

    cyc        = 1;
    last_hs    = (len == 0) ? 0 : -1;
    finished   = 1'b0;
    prev_stall = 1'b0;
    prev_data  = '0;
    while (!finished && cyc < 2000) begin
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (cyc % 3 == 1);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      exp_done = (last_hs >= 0) && (cyc == last_hs + 1);
      exp_busy = !((last_hs >= 0) && (cyc > last_hs));
      check_eq("done", bus.done, exp_done);
      check_eq("busy", bus.busy, exp_busy);
      if (chk_lat) begin
        check_eq("valid_latency", bus.out_valid, (cyc >= 3) && (cyc < 3 + len));
        if (cyc <= len) check_eq("gb_index", bus.gb_index, ref_index(base, cyc - 1, step));
      end
      if (len == 0) begin
        check_eq("zero_len_index", bus.gb_index, idx_before);
        check_eq("zero_len_valid", bus.out_valid, 0);
      end
      if (prev_stall) begin
        check_eq("stall_valid", bus.out_valid, 1);
        check_eq("stall_data", bus.out_data, prev_data);
      end
      if (bus.out_valid) begin
        if (exp_data.size() == 0) begin
          check_eq("extra_word", bus.out_valid, 0);
        end else begin
          check_eq("out_data", bus.out_data, exp_data[0]);
          check_eq("out_last", bus.out_last, exp_last[0]);
          if (bus.out_ready) begin
            void'(exp_data.pop_front());
            void'(exp_last.pop_front());
            if (exp_data.size() == 0) last_hs = cyc;
          end
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      if (exp_done) finished = 1'b1;
      @(negedge clk);
      cyc++;
    end
    check_eq("burst_completed", finished, 1);
    check_eq("words_left", exp_data.size(), 0);
    #1;
    check_eq("post_done", bus.done, 0);
    check_eq("post_busy", bus.busy, 0);
    check_eq("post_valid", bus.out_valid, 0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, len, step, mode;
    for (int i = 0; i < 256; i++) mem[i] = DATA_W'(i + 'h100);
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.base_idx  = '0;
    bus.length    = '0;
    bus.out_ready = 1'b0;
`ifdef GBUF_RD_STRIDE_EN
    bus.stride    = '0;
`endif
    repeat (2) @(negedge clk);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_valid", bus.out_valid, 0);
    check_eq("rst_last", bus.out_last, 0);
    check_eq("rst_data", bus.out_data, 0);
    check_eq("rst_index", bus.gb_index, 0);
    check_eq("rst_wr_en", bus.gb_wr_en, 0);
    rst = 1'b0;

    run_burst(4, 5, 1, 0, 1'b1);
    run_burst(4, 5, 1, 1, 1'b0);
    run_burst(254, 4, 1, 0, 1'b1);
    run_burst(10, 0, 1, 0, 1'b1);

    // Reset while the third word of a length-8 burst is on the output.
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    bus.base_idx  = '0;
    bus.length    = LEN_W'(8);
`ifdef GBUF_RD_STRIDE_EN
    bus.stride    = IDX_W'(1);
`endif
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check_eq("pre_rst_word", bus.out_data, 'h102);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_busy", bus.busy, 0);
    check_eq("mid_rst_done", bus.done, 0);
    check_eq("mid_rst_valid", bus.out_valid, 0);
    check_eq("mid_rst_last", bus.out_last, 0);
    check_eq("mid_rst_data", bus.out_data, 0);
    check_eq("mid_rst_index", bus.gb_index, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b0;
    run_burst(0, 2, 1, 0, 1'b1);

`ifdef GBUF_RD_STRIDE_EN
    run_burst(0, 3, 16, 0, 1'b1);
    run_burst(9, 4, 0, 2, 1'b0);
`endif
    run_burst(7, 256, 1, 2, 1'b0);

    for (int i = 0; i < 30; i++) begin
      base = $urandom_range(0, 255);
      len  = $urandom_range(0, 12);
      mode = $urandom_range(0, 2);
`ifdef GBUF_RD_STRIDE_EN
      step = $urandom_range(0, 255);
`else
      step = 1;
`endif
      run_burst(base, len, step, mode, mode == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gbuff_stream_reader.md
Name: gbuff_stream_reader

Overview:
Read-side controller for a global buffer bank. On a start command it issues a burst of read indices to the buffer and absorbs the buffer's fixed 1-cycle registered read latency. It delivers each word on a valid/ready stream towards the systolic-array operand feeders. A 2-entry skid FIFO keeps throughput at 1 word/cycle under backpressure without losing in-flight reads.

Parameters:
DATA_W, 32, word width; matches the buffer word size.
IDX_W, 8, buffer index width (256 entries).
LEN_W, 9, burst length width (0..256 words).

Ports:
clk  in  1  clock.
rst  in  1  reset; asynchronous, active-high.
start  in  1  burst request; sampled only in IDLE.
base_idx  in  IDX_W  first buffer index of the burst.
length  in  LEN_W  number of words to read.
busy  out  1  high while a burst is in progress.
done  out  1  one-cycle pulse after the last word is accepted downstream.
gb_wr_en  out  1  buffer write enable; constant 0.
gb_index  out  IDX_W  buffer read index.
gb_data  in  DATA_W  buffer registered read data; valid the cycle after its index is presented.
out_valid  out  1  stream word valid.
out_ready  in  1  downstream accept.
out_data  out  DATA_W  stream word.
out_last  out  1  high with the final word of the burst.

Behaviour:
- Reset (async, any time, including mid-burst): state IDLE; busy=0, done=0, out_valid=0, out_last=0, out_data=0, gb_index=0, gb_wr_en=0. FIFO is emptied, counters are cleared, and any in-flight read is discarded.
- States:
  - IDLE -> FETCH on start with length!=0.
  - IDLE -> DONE on start with length==0.
  - FETCH -> DRAIN when all reads are issued.
  - DRAIN -> DONE when the last word is accepted (out_valid&out_ready&out_last).
  - DONE -> IDLE unconditionally after one cycle.
- busy=1 in FETCH and DRAIN. done=1 only in DONE. start is ignored when not in IDLE.
- Issue rule: a read is issued in a cycle when state is FETCH and (fifo_count + inflight - pop) < 2, where pop = out_valid&out_ready. When a read is issued, gb_index presents the current index and inflight is set for the next cycle.
- Capture: when inflight=1, gb_data is pushed into the FIFO in that cycle. No read is ever issued without guaranteed FIFO space.
- Index arithmetic: index(n) = base_idx + n*step, modulo 2^IDX_W. 255 wraps to 0 with no error.
- gb_index holds its last value when no read is issued.
- Latency with out_ready held high: start sampled at edge T; gb_index=base_idx during T+1; word 0 is on out_valid/out_data during T+3; one word per cycle thereafter. done asserts the cycle after the last handshake.
- out_data/out_valid come from the FIFO head. Both are stable while out_valid=1 and out_ready=0.
- out_last is high on the head word with ordinal length-1.
- Ordering: words leave in issue order. There is no duplication or loss under any out_ready pattern.

Optional Feature:
GBUF_RD_STRIDE_EN
- Defined: extra input port stride (IDX_W bits, unsigned), sampled at start; step = stride. stride=0 re-reads base_idx length times.
- Undefined: no stride port; step = 1.

Decomposition:
- Shared package/define file: DATA_W, IDX_W and LEN_W defaults, tied to the existing word-size and index-size defines.
- Shared package/define file: state encoding constants IDLE=2'd0, FETCH=2'd1, DRAIN=2'd2, DONE=2'd3.
- One sub-module: gbuff_skid_fifo, a 2-entry DATA_W+1-bit FIFO (data plus last flag) with push/pop/count. Simultaneous push and pop while full or empty are legal.

Test Plan:
- Buffer model preloaded with mem[i]=i+0x100; start base=4, length=5, out_ready=1 -> out_data 0x104..0x108 on consecutive cycles T+3..T+7; out_last only on 0x108; done at T+8.
- Same burst with out_ready toggling 1,0,0,1,... -> same 5 words in order, none dropped or duplicated; out_data stable during stalls; inflight+fifo never exceeds 2.
- base=254, length=4 -> gb_index sequence 254, 255, 0, 1; data 0x1FE, 0x1FF, 0x100, 0x101.
- length=0 -> no gb_index activity and no out_valid; done pulses at T+1; busy stays 0.
- Assert rst during the 3rd word of a length-8 burst -> all outputs 0 immediately; a new start base=0, length=2 then yields 0x100, 0x101 only.
- With GBUF_RD_STRIDE_EN: base=0, stride=16, length=3 -> indices 0, 16, 32; data 0x100, 0x110, 0x120.
